// File: rtl/pwm_deadtime_out.sv
// pwm_deadtime_out
//   Output stage for the noise-shaping modulator. Takes one duty word per PWM
//   period and turns it into a complementary high/low drive pair, with both
//   drives held low for DEADTIME cycles around every transition.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (synchronously released upstream)
//   enable      1 = run PWM; 0 = drives off, period counter parked at 0
//   value       unsigned duty in clk counts, sampled once per period
//   sample_stb  one-cycle pulse in the cycle 'value' is captured
//   clip        pulses together with sample_stb when value exceeds PERIOD
//   pwm_hi      high-side drive
//   pwm_lo      low-side drive, complement of pwm_hi outside dead time
module pwm_deadtime_out #(
    parameter int unsigned PERIOD   = 1024,
    parameter int unsigned DEADTIME = 4,
    parameter int unsigned CNTW     = 16,
    parameter int unsigned DTW      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] value,
    output logic        sample_stb,
    output logic        clip,
    output logic        pwm_hi,
    output logic        pwm_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(PERIOD - 1);
    localparam logic [16:0]     PERIOD_EXT = 17'(PERIOD);
    localparam logic [15:0]     DUTY_MAX   = 16'(PERIOD);
    localparam logic [DTW-1:0]  DT_LOAD    = DTW'(DEADTIME);
    localparam logic [DTW-1:0]  DT_ONE     = DTW'(1);

    logic [CNTW-1:0] cnt;
    logic [15:0]     duty_q;
    logic            raw;
    logic            tgt;
    logic [DTW-1:0]  dcnt;
    state_t          state;

    // ------------------------------------------------------------------
    // Period counter and duty capture
    // ------------------------------------------------------------------
    assign sample_stb = enable & (cnt == CNT_LAST);
    assign clip       = sample_stb & ({1'b0, value} > PERIOD_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only the strobe cycle loads the duty, so a mid-period change of
    // 'value' cannot disturb the period in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else if (sample_stb) begin
            duty_q <= clip ? DUTY_MAX : value;
        end
    end

    // Both sides widened to 32 bits so any CNTW compares cleanly against
    // the 16-bit duty. duty_q=0 never matches, duty_q=PERIOD always does,
    // so the extremes stay flat across the wrap.
    assign raw = (32'(cnt) < 32'(duty_q));

    // ------------------------------------------------------------------
    // Dead-time FSM with registered drives
    // ------------------------------------------------------------------
    // dcnt is loaded with DEADTIME on entry to DEAD and counts down each
    // cycle; the exit is taken on the edge where it reaches zero, giving
    // exactly DEADTIME cycles with both drives low. A raw change while in
    // DEAD restarts the interval towards the new target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tgt    <= 1'b0;
            dcnt   <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            dcnt   <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DEADTIME == 0) begin
                        state  <= raw ? HI : LO;
                        pwm_hi <= raw;
                        pwm_lo <= ~raw;
                    end else begin
                        state  <= DEAD;
                        tgt    <= raw;
                        dcnt   <= DT_LOAD;
                        pwm_hi <= 1'b0;
                        pwm_lo <= 1'b0;
                    end
                end

                DEAD: begin
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                    if (raw != tgt) begin
                        tgt  <= raw;
                        dcnt <= DT_LOAD;
                    end else if (dcnt <= DT_ONE) begin
                        dcnt   <= '0;
                        state  <= tgt ? HI : LO;
                        pwm_hi <= tgt;
                        pwm_lo <= ~tgt;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end

                HI: begin
                    if (!raw) begin
                        pwm_hi <= 1'b0;
                        if (DEADTIME == 0) begin
                            state  <= LO;
                            pwm_lo <= 1'b1;
                        end else begin
                            state  <= DEAD;
                            tgt    <= 1'b0;
                            dcnt   <= DT_LOAD;
                            pwm_lo <= 1'b0;
                        end
                    end else begin
                        pwm_hi <= 1'b1;
                        pwm_lo <= 1'b0;
                    end
                end

                LO: begin
                    if (raw) begin
                        pwm_lo <= 1'b0;
                        if (DEADTIME == 0) begin
                            state  <= HI;
                            pwm_hi <= 1'b1;
                        end else begin
                            state  <= DEAD;
                            tgt    <= 1'b1;
                            dcnt   <= DT_LOAD;
                            pwm_hi <= 1'b0;
                        end
                    end else begin
                        pwm_hi <= 1'b0;
                        pwm_lo <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_out.sv
// tb_pwm_deadtime_out
//   Two instances share one stimulus stream: PERIOD=16 with DEADTIME=0 and
//   with DEADTIME=2. The reference model describes the drives as windows over
//   the ideal PWM history: a drive is on in a cycle iff the ideal waveform was
//   at that level, with enable high, for each of the previous DEADTIME+1
//   cycles.
module tb_pwm_deadtime_out;

    localparam int unsigned P = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic        stb0, clip0, hi0, lo0;
    logic        stb2, clip2, hi2, lo2;

    always #5 clk = ~clk;

    pwm_deadtime_out #(.PERIOD(16), .DEADTIME(0), .CNTW(8), .DTW(3)) u_dt0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value),
        .sample_stb(stb0), .clip(clip0), .pwm_hi(hi0), .pwm_lo(lo0)
    );

    pwm_deadtime_out #(.PERIOD(16), .DEADTIME(2), .CNTW(8), .DTW(3)) u_dt2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value),
        .sample_stb(stb2), .clip(clip2), .pwm_hi(hi2), .pwm_lo(lo2)
    );

    typedef struct {
        int   cyc;
        logic hi0, lo0, hi2, lo2, stb, clip;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int unsigned phase  = 0;
    int unsigned duty_m = 0;
    bit          en_h[$];
    bit          raw_h[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // 1 iff the last d+1 recorded cycles were all enabled with ideal PWM == level
    function automatic logic window(input int d, input bit level);
        int n;
        n = en_h.size();
        if (n < d + 1) return 1'b0;
        for (int k = 0; k <= d; k++) begin
            if (!en_h[n-1-k] || raw_h[n-1-k] != level) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one cycle and push its expected outputs.
    task automatic step(input logic en, input logic [15:0] val);
        exp_t e;
        bit   raw_t;
        @(posedge clk);
        #1;
        enable = en;
        value  = val;
        cyc++;
        raw_t  = (phase < duty_m);
        e.cyc  = cyc;
        e.hi0  = window(0, 1'b1);
        e.lo0  = window(0, 1'b0);
        e.hi2  = window(2, 1'b1);
        e.lo2  = window(2, 1'b0);
        e.stb  = en && (phase == P - 1);
        e.clip = e.stb && (val > P);
        exp_q.push_back(e);
        en_h.push_back(en);
        raw_h.push_back(raw_t);
        if (en_h.size() > 8) begin
            void'(en_h.pop_front());
            void'(raw_h.pop_front());
        end
        if (e.stb) duty_m = (val > P) ? P : int'(val);
        phase = en ? (phase + 1) % P : 0;
    endtask

    task automatic run(input int n, input logic [15:0] val);
        for (int i = 0; i < n; i++) step(1'b1, val);
    endtask

    // Step enabled until the next cycle will have the given counter phase.
    task automatic wait_phase(input int unsigned ph, input logic [15:0] val);
        int guard;
        guard = 0;
        while (phase != ph && guard < 2 * int'(P)) begin
            step(1'b1, val);
            guard++;
        end
        checks++;
        if (phase != ph) begin
            errors++;
            $display("FAIL wait_phase cycle %0d: got phase %0d required %0d", cyc, phase, ph);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_hi0"}, hi0, 1'b0);
        check({tag, "_lo0"}, lo0, 1'b0);
        check({tag, "_hi2"}, hi2, 1'b0);
        check({tag, "_lo2"}, lo2, 1'b0);
        check({tag, "_stb0"}, stb0, 1'b0);
        check({tag, "_stb2"}, stb2, 1'b0);
    endtask

    // Monitor: never both drives on; compare each driven cycle in order.
    always @(negedge clk) begin
        exp_t e;
        check("overlap_dt0", hi0 & lo0, 1'b0);
        check("overlap_dt2", hi2 & lo2, 1'b0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hi_dt0",   hi0,   e.hi0);
            check("lo_dt0",   lo0,   e.lo0);
            check("hi_dt2",   hi2,   e.hi2);
            check("lo_dt2",   lo2,   e.lo2);
            check("stb_dt0",  stb0,  e.stb);
            check("stb_dt2",  stb2,  e.stb);
            check("clip_dt0", clip0, e.clip);
            check("clip_dt2", clip2, e.clip);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic        en;

        rst_n  = 1'b0;
        enable = 1'b0;
        value  = '0;
        repeat (3) begin
            @(negedge clk);
            check_all_low("reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Duty 4, then the extremes and an over-range value
        run(3 * P, 16'd4);
        run(3 * P, 16'd0);
        run(3 * P, 16'd16);
        run(3 * P, 16'd20);

        // Duty 8: symmetric dead-time gaps
        run(3 * P, 16'd8);

        // Mid-period change 4 -> 10 at cnt=7 only shows up next period
        run(2 * P, 16'd4);
        wait_phase(7, 16'd4);
        run(3 * P, 16'd10);

        // Drop enable at cnt=5 with the high side on, then re-enable
        run(2 * P, 16'd8);
        wait_phase(5, 16'd8);
        for (int i = 0; i < 4; i++) step(1'b0, 16'd3);
        run(3 * P, 16'd8);

        // Enable low exactly in the wrap cycle: no strobe, no capture
        wait_phase(15, 16'd8);
        step(1'b0, 16'd20);
        step(1'b0, 16'd20);
        run(2 * P, 16'd8);

        // Randomized duty changes and occasional enable drops
        v = 16'd6;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) v = 16'($urandom_range(0, 24));
            en = ($urandom_range(0, 39) != 0);
            step(en, v);
        end

        // Asynchronous reset while the high side is on
        run(2 * P, 16'd8);
        wait_phase(4, 16'd8);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_hi0", hi0, 1'b0);
        check("async_rst_hi2", hi2, 1'b0);
        check("async_rst_lo0", lo0, 1'b0);
        check("async_rst_lo2", lo2, 1'b0);
        enable = 1'b0;
        duty_m = 0;
        phase  = 0;
        en_h.delete();
        raw_h.delete();
        repeat (2) begin
            @(negedge clk);
            check_all_low("in_reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Duty cleared by reset: high side stays off until the first capture
        run(P, 16'd12);
        run(3 * P, 16'd12);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
